// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-op encodings and the result-buffer occupancy states.
package alu_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND   = 3'b000;
    localparam op_t OP_OR    = 3'b001;
    localparam op_t OP_NAND  = 3'b010;
    localparam op_t OP_NOR   = 3'b011;
    localparam op_t OP_XOR   = 3'b100;
    localparam op_t OP_XNOR  = 3'b101;
    localparam op_t OP_NOTA  = 3'b110;
    localparam op_t OP_PASSB = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise op mux with zero/negative flags.
// With LOGIC_OP_PARITY_EN defined it also returns the XOR-reduction of the result.
module logic_op_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
`ifdef LOGIC_OP_PARITY_EN
    output logic             parity,
`endif
    output logic             neg
);

    always_comb begin
        result = '0;
        case (op)
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_NAND:  result = ~(a & b);
            OP_NOR:   result = ~(a | b);
            OP_XOR:   result = a ^ b;
            OP_XNOR:  result = ~(a ^ b);
            OP_NOTA:  result = ~a;
            OP_PASSB: result = b;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);
    assign neg  = result[WIDTH-1];
`ifdef LOGIC_OP_PARITY_EN
    assign parity = ^result;
`endif

endmodule

// File: rtl/logic_op_stage.sv
// Pipelined bitwise logic stage: valid/ready in, 2-entry skid buffer out, saturating op counter.
// Optional out_parity port and per-entry parity storage under LOGIC_OP_PARITY_EN.
module logic_op_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_neg,
`ifdef LOGIC_OP_PARITY_EN
    output logic             out_parity,
`endif
    output logic [CNT_W-1:0] op_count,
    output buf_state_t       state_dbg
);

    // A transfer happens on a clock edge when valid and ready are both high;
    // in_ready is registered so upstream never sees a path from out_ready.
    logic [WIDTH-1:0] res;
    logic             res_zero;
    logic             res_neg;

    buf_state_t       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;
    logic             head_zero_q, head_zero_d, skid_zero_q, skid_zero_d;
    logic             head_neg_q, head_neg_d, skid_neg_q, skid_neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_fire, out_fire;
`ifdef LOGIC_OP_PARITY_EN
    logic             res_parity;
    logic             head_par_q, head_par_d, skid_par_q, skid_par_d;
`endif

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .a      (in_a),
        .b      (in_b),
        .op     (op_t'(in_op)),
        .result (res),
        .zero   (res_zero),
`ifdef LOGIC_OP_PARITY_EN
        .parity (res_parity),
`endif
        .neg    (res_neg)
    );

    always_comb begin
        in_fire     = in_valid & in_ready_q;
        out_fire    = (state_q != ST_EMPTY) & out_ready;
        state_d     = state_q;
        head_data_d = head_data_q;
        head_zero_d = head_zero_q;
        head_neg_d  = head_neg_q;
        skid_data_d = skid_data_q;
        skid_zero_d = skid_zero_q;
        skid_neg_d  = skid_neg_q;
`ifdef LOGIC_OP_PARITY_EN
        head_par_d  = head_par_q;
        skid_par_d  = skid_par_q;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d     = ST_ONE;
                    head_data_d = res;
                    head_zero_d = res_zero;
                    head_neg_d  = res_neg;
`ifdef LOGIC_OP_PARITY_EN
                    head_par_d  = res_parity;
`endif
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    head_data_d = res;
                    head_zero_d = res_zero;
                    head_neg_d  = res_neg;
`ifdef LOGIC_OP_PARITY_EN
                    head_par_d  = res_parity;
`endif
                end else if (in_fire) begin
                    state_d     = ST_FULL;
                    skid_data_d = res;
                    skid_zero_d = res_zero;
                    skid_neg_d  = res_neg;
`ifdef LOGIC_OP_PARITY_EN
                    skid_par_d  = res_parity;
`endif
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the skid promotion can happen.
                if (out_fire) begin
                    state_d     = ST_ONE;
                    head_data_d = skid_data_q;
                    head_zero_d = skid_zero_q;
                    head_neg_d  = skid_neg_q;
`ifdef LOGIC_OP_PARITY_EN
                    head_par_d  = skid_par_q;
`endif
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        in_ready_d = (state_d != ST_FULL);
        cnt_d      = (out_fire && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            head_data_q <= '0;
            head_zero_q <= 1'b1;
            head_neg_q  <= 1'b0;
            skid_data_q <= '0;
            skid_zero_q <= 1'b1;
            skid_neg_q  <= 1'b0;
            cnt_q       <= '0;
`ifdef LOGIC_OP_PARITY_EN
            head_par_q  <= 1'b0;
            skid_par_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            head_data_q <= head_data_d;
            head_zero_q <= head_zero_d;
            head_neg_q  <= head_neg_d;
            skid_data_q <= skid_data_d;
            skid_zero_q <= skid_zero_d;
            skid_neg_q  <= skid_neg_d;
            cnt_q       <= cnt_d;
`ifdef LOGIC_OP_PARITY_EN
            head_par_q  <= head_par_d;
            skid_par_q  <= skid_par_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = head_data_q;
    assign out_zero  = head_zero_q;
    assign out_neg   = head_neg_q;
    assign op_count  = cnt_q;
    assign state_dbg = state_q;
`ifdef LOGIC_OP_PARITY_EN
    assign out_parity = head_par_q;
`endif

endmodule

// File: tb/tb_logic_op_stage.sv
// Self-checking bench for logic_op_stage: directed ops/flags/backpressure/reset plus random streaming.
module tb_logic_op_stage;
    import alu_pkg::*;

    localparam int W     = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_zero;
    logic             out_neg;
    logic [CNT_W-1:0] op_count;
    buf_state_t       state_dbg;
`ifdef LOGIC_OP_PARITY_EN
    logic             out_parity;
`endif

    logic_op_stage #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
`ifdef LOGIC_OP_PARITY_EN
        .out_parity(out_parity),
`endif
        .op_count  (op_count),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] exp_q[$];
    int           model_cnt = 0;
    bit           started = 1'b0;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return b;
        endcase
    endfunction

    // Scoreboard: inputs are stable between posedge+1 and the next posedge,
    // so the negedge sees exactly what the coming edge will act on.
    always @(negedge clk) begin
        if (started) begin
            check("occ", W'(state_dbg), W'(exp_q.size()));
            check("in_ready", W'(in_ready), W'(exp_q.size() < 2));
            check("out_valid", W'(out_valid), W'(exp_q.size() != 0));
            check("op_count", W'(op_count), W'(model_cnt));
            if (exp_q.size() != 0) begin
                check("head_data", out_data, exp_q[0]);
                check("head_zero", W'(out_zero), W'(exp_q[0] == '0));
                check("head_neg", W'(out_neg), W'(exp_q[0][W-1]));
`ifdef LOGIC_OP_PARITY_EN
                check("head_parity", W'(out_parity), W'(^exp_q[0]));
`endif
            end
            if (!rst_n) begin
                exp_q.delete();
                model_cnt = 0;
            end else begin
                bit in_acc;
                in_acc = in_valid && (exp_q.size() < 2);
                if (out_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    if (model_cnt < (1 << CNT_W) - 1) model_cnt++;
                end
                if (in_acc) exp_q.push_back(ref_op(in_a, in_b, in_op));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        output int waits);
        bit acc;
        acc = 1'b0;
        waits = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            step();
            waits++;
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    logic [W-1:0] op_exp [8];
    int           w;

    initial begin
        // Hand-derived for a=F0F0_1234, b=0FF0_FFFF, ops 000..111.
        op_exp[0] = 32'h00F0_1234;
        op_exp[1] = 32'hFFF0_FFFF;
        op_exp[2] = 32'hFF0F_EDCB;
        op_exp[3] = 32'h000F_0000;
        op_exp[4] = 32'hFF00_EDCB;
        op_exp[5] = 32'h00FF_1234;
        op_exp[6] = 32'h0F0F_EDCB;
        op_exp[7] = 32'h0FF0_FFFF;

        rst_n = 1'b0;
        in_valid = 1'b1;
        in_a = 32'hDEAD_BEEF;
        in_b = 32'h1234_5678;
        in_op = 3'd4;
        out_ready = 1'b0;

        // Reset with in_valid held high: nothing may be captured.
        step();
        started = 1'b1;
        step();
        @(negedge clk);
        check("rst_out_valid", W'(out_valid), 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_zero", W'(out_zero), 1);
        check("rst_out_neg", W'(out_neg), 0);
        check("rst_op_count", W'(op_count), 0);
        check("rst_in_ready", W'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        @(negedge clk);
        check("rst_no_capture", W'(out_valid), 0);
        step();

        // Op sweep, one-cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(32'hF0F0_1234, 32'h0FF0_FFFF, 3'(i), w);
            @(negedge clk);
            check("op_valid", W'(out_valid), 1);
            check($sformatf("op_%0d", i), out_data, op_exp[i]);
            step();
        end

        // Flags.
        send(32'hFFFF_FFFF, 32'h0, 3'd0, w);
        @(negedge clk);
        check("flag_zero", W'(out_zero), 1);
        check("flag_zero_neg", W'(out_neg), 0);
        step();
        send(32'h0, 32'h8000_0000, 3'd7, w);
        @(negedge clk);
        check("flag_neg", W'(out_neg), 1);
        check("flag_neg_zero", W'(out_zero), 0);
        step();

        // Backpressure: two captured, third held until the skid drains.
        out_ready = 1'b0;
        send(32'h1111_0000, 32'h0000_2222, 3'd1, w);
        send(32'hAAAA_5555, 32'hFFFF_0000, 3'd4, w);
        @(negedge clk);
        check("bp_full", W'(in_ready), 0);
        step();
        in_valid = 1'b1;
        in_a = 32'h0;
        in_b = 32'h7777_7777;
        in_op = 3'd7;
        repeat (3) step();
        out_ready = 1'b1;
        send(32'h0, 32'h7777_7777, 3'd7, w);
        check("bp_wait", W'(w), 2);
        repeat (4) step();

        // Reset while FULL discards both entries.
        out_ready = 1'b0;
        send(32'h0000_00FF, 32'h0000_0F0F, 3'd0, w);
        send(32'h0000_00FF, 32'h0000_0F0F, 3'd5, w);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rstfull_valid", W'(out_valid), 0);
        check("rstfull_count", W'(op_count), 0);
        check("rstfull_ready", W'(in_ready), 1);
        step();

        // Throughput: 100 back-to-back cycles from an empty, zero-count start.
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_a = $urandom;
            in_b = $urandom;
            in_op = 3'($urandom_range(0, 7));
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("thru_count", W'(op_count), 99);
        step();

        // Random traffic past the counter ceiling.
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 7) != 0);
            in_a = $urandom;
            in_b = $urandom;
            in_op = 3'($urandom_range(0, 7));
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check("sat_count", W'(op_count), W'((1 << CNT_W) - 1));
        step();

`ifdef LOGIC_OP_PARITY_EN
        send(32'h0, 32'h0000_0007, 3'd7, w);
        @(negedge clk);
        check("parity_7", W'(out_parity), 1);
        step();
`endif

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
